ifm_bram_ctrl: RTL

IFM_BRAM_CTRL -- requirements
Module: ifm_bram_ctrl

---
 rtl/ifm_ctrl_pkg.sv | 15 +
 rtl/ifm_rd_skid.sv | 48 ++++
 rtl/ifm_bram_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/ifm_ctrl_pkg.sv
// Shared definitions for the IFM BRAM controller: job states and word geometry.
package ifm_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        READ,
        DRAIN,
        DONE
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int DEFAULT_DEPTH  = 100352;

endpackage

// File: rtl/ifm_rd_skid.sv
// Two-entry FIFO that absorbs BRAM read data so the read stream can stall without loss.
module ifm_rd_skid #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_pop,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [1:0]            o_count
);

    logic [DATA_WIDTH-1:0] r_mem [0:1];
    logic                  r_wrPtr;
    logic                  r_rdPtr;
    logic [1:0]            r_count;
    logic                  w_pop;
    logic                  w_push;

    assign o_valid = (r_count != 2'd0);
    assign o_data  = r_mem[r_rdPtr];
    assign o_count = r_count;
    assign w_pop   = i_pop && o_valid;
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign w_push  = i_push && ((r_count != 2'd2) || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wrPtr  <= 1'b0;
            r_rdPtr  <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wrPtr] <= i_data;
                r_wrPtr        <= ~r_wrPtr;
            end
            if (w_pop) begin
                r_rdPtr <= ~r_rdPtr;
            end
            r_count <= r_count + 2'(w_push) - 2'(w_pop);
        end
    end

endmodule

// File: rtl/ifm_bram_ctrl.sv
// Input-feature-map BRAM controller: loads a beat stream into BRAM, then streams a
// rows x cols window of 32-bit words back out through a two-entry skid buffer.
module ifm_bram_ctrl
    import ifm_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int IN_WIDTH   = 128,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int ADDR_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    input  logic [31:0]           cfg_wr_words,
    input  logic [31:0]           cfg_rd_base,
    input  logic [15:0]           cfg_rd_rows,
    input  logic [15:0]           cfg_rd_cols,
    input  logic [31:0]           cfg_row_pitch,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_WIDTH-1:0]   in_data,
    output logic                  bram_wr_rd_en,
    output logic [ADDR_W-1:0]     bram_wr_addr,
    output logic [ADDR_W-1:0]     bram_rd_addr,
    output logic [IN_WIDTH-1:0]   bram_data_in,
    input  logic [DATA_WIDTH-1:0] bram_data_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
);

    state_t              r_state;
    state_t              w_nextState;
    logic [31:0]         r_wrWords;
    logic [31:0]         r_wrCnt;
    logic [15:0]         r_rows;
    logic [15:0]         r_cols;
    logic [15:0]         r_row;
    logic [15:0]         r_col;
    logic [ADDR_W-1:0]   r_pitch;
    logic [ADDR_W-1:0]   r_rowBase;
    logic [ADDR_W-1:0]   r_colOff;
    logic [ADDR_W-1:0]   r_lastAddr;
    logic                r_pend;
    logic                r_pendLast;
    logic                w_fire;
    logic                w_readEmpty;
    logic                w_lastCol;
    logic                w_lastRow;
    logic                w_pop;
    logic                w_issue;
    logic [1:0]          w_fifoCount;
    logic [1:0]          w_occ;
    logic [ADDR_W-1:0]   w_curAddr;
    logic                w_fifoValid;
    logic [DATA_WIDTH:0] w_fifoHead;

    assign busy          = (r_state != IDLE);
    assign done          = (r_state == DONE);
    assign in_ready      = (r_state == LOAD) && (r_wrCnt != r_wrWords);
    assign w_fire        = in_valid && in_ready;
    assign bram_wr_rd_en = w_fire && (r_wrCnt < 32'(DEPTH));
    assign bram_wr_addr  = (r_state == LOAD) ? ADDR_W'(r_wrCnt) : '0;
    assign bram_data_in  = w_fire ? in_data : '0;

    assign w_readEmpty = (r_rows == 16'd0) || (r_cols == 16'd0);
    assign w_lastCol   = (r_col == r_cols - 16'd1);
    assign w_lastRow   = (r_row == r_rows - 16'd1);
    assign w_pop       = out_valid && out_ready;
    // Occupancy counts the word leaving this cycle as gone, which keeps reads back-to-back.
    assign w_occ       = 2'(r_pend) + w_fifoCount - 2'(w_pop);
    assign w_issue     = (r_state == READ) && !w_readEmpty && (w_occ < 2'd2);
    assign w_curAddr   = r_rowBase + r_colOff;
    assign bram_rd_addr = w_issue ? w_curAddr : r_lastAddr;

    assign out_valid = w_fifoValid;
    assign out_data  = w_fifoHead[DATA_WIDTH-1:0];
    assign out_last  = w_fifoValid && w_fifoHead[DATA_WIDTH];

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:  if (start) w_nextState = LOAD;
            LOAD:  if ((r_wrCnt == r_wrWords) ||
                       (w_fire && (r_wrCnt + 32'd1 == r_wrWords))) w_nextState = READ;
            READ:  if (w_readEmpty) w_nextState = DONE;
                   else if (w_issue && w_lastCol && w_lastRow) w_nextState = DRAIN;
            DRAIN: if (w_pop && out_last) w_nextState = DONE;
            DONE:  w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Row offset accumulates pitch per row so no multiplier is needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrWords  <= '0;
            r_wrCnt    <= '0;
            r_rows     <= '0;
            r_cols     <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_pitch    <= '0;
            r_rowBase  <= '0;
            r_colOff   <= '0;
            r_lastAddr <= '0;
            r_pend     <= 1'b0;
            r_pendLast <= 1'b0;
        end else begin
            if ((r_state == IDLE) && start) begin
                r_wrWords <= cfg_wr_words;
                r_rows    <= cfg_rd_rows;
                r_cols    <= cfg_rd_cols;
                r_pitch   <= ADDR_W'(cfg_row_pitch);
                r_rowBase <= ADDR_W'(cfg_rd_base);
                r_colOff  <= '0;
                r_row     <= '0;
                r_col     <= '0;
                r_wrCnt   <= '0;
            end
            if (w_fire) begin
                r_wrCnt <= r_wrCnt + 32'd1;
            end
            if (w_issue) begin
                r_lastAddr <= w_curAddr;
                if (w_lastCol) begin
                    r_col     <= '0;
                    r_colOff  <= '0;
                    r_row     <= r_row + 16'd1;
                    r_rowBase <= r_rowBase + r_pitch;
                end else begin
                    r_col    <= r_col + 16'd1;
                    r_colOff <= r_colOff + ADDR_W'(BYTES_PER_WORD);
                end
            end
            r_pend     <= w_issue;
            r_pendLast <= w_issue && w_lastCol && w_lastRow;
        end
    end

    ifm_rd_skid #(
        .DATA_WIDTH(DATA_WIDTH + 1)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_pend),
        .i_data  ({r_pendLast, bram_data_out}),
        .i_pop   (w_pop),
        .o_valid (w_fifoValid),
        .o_data  (w_fifoHead),
        .o_count (w_fifoCount)
    );

endmodule
